layer_compositor: RTL and testbench

- Parametrised successor to the hand-written priority pixel mux and full-screen image address logic in the game top level.
- Merges NUM_LAYERS sprite/UI layers by fixed priority, with per-layer colour-key transparency.
- Adds a full-screen image mode (static or multi-frame animation) that drives a synchronous image ROM.
- Registers the final 12-bit RGB on pixel_tick; the top level connects its output straight to VGA_RED/GREEN/BLUE.

---
 rtl/layer_compositor_pkg.sv | 34 +++
 rtl/layer_compositor_anim_sequencer.sv | 95 +++++++++
 rtl/layer_compositor.sv | 199 +++++++++++++++++++
 tb/tb_layer_compositor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor_pkg
//  Description : Shared constants and types for the layer compositor: colour
//                defaults, display-mode encodings, VGA geometry and the
//                animation sequencer state type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package layer_compositor_pkg;

    localparam int          c_rgb_w         = 12;
    localparam logic [11:0] c_key_color_def = 12'h0f0;
    localparam logic [11:0] c_bg_color_def  = 12'hAAA;

    localparam int c_vga_w   = 640;
    localparam int c_vga_h   = 480;
    // Both pixel coordinates share one width, sized for the larger axis.
    localparam int c_coord_w = $clog2((c_vga_w > c_vga_h) ? c_vga_w : c_vga_h);

    typedef enum logic [1:0] {
        MODE_LAYERS  = 2'd0,
        MODE_IMG     = 2'd1,
        MODE_ANIM    = 2'd2,
        MODE_IMG_KEY = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        ANIM_IDLE = 1'b0,
        ANIM_RUN  = 1'b1
    } anim_state_e;

endpackage : layer_compositor_pkg
`default_nettype wire

// File: rtl/layer_compositor_anim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor_anim_sequencer
//  Description : Animation frame sequencer. Counts VGA frame_start pulses while
//                animation is enabled and advances frame_idx every FRAME_TICKS
//                pulses, wrapping after NUM_FRAMES frames.
//  Ports       : clk         - system clock
//                reset       - synchronous active-high reset
//                anim_en     - animation mode selected
//                frame_start - one-cycle pulse per VGA frame
//                frame_idx   - current animation frame
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor_anim_sequencer
    import layer_compositor_pkg::*;
#(
    parameter int NUM_FRAMES  = 2,
    parameter int FRAME_TICKS = 24,
    parameter int FRAME_W     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               anim_en,
    input  logic               frame_start,
    output logic [FRAME_W-1:0] frame_idx
);

    localparam int                 CNT_W        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0]   c_cnt_last   = CNT_W'(FRAME_TICKS - 1);
    localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(NUM_FRAMES - 1);

    anim_state_e        r_state;
    anim_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ANIM_IDLE;
            r_cnt   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    // A frame_start arriving while still IDLE (the cycle the mode switches to
    // animation) is ignored; likewise a pulse coinciding with leaving the
    // mode, because the leave branch takes precedence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = r_frame;
        case (r_state)
            ANIM_IDLE: begin
                w_cnt_nxt   = '0;
                w_frame_nxt = '0;
                if (anim_en) begin
                    w_state_nxt = ANIM_RUN;
                end
            end
            ANIM_RUN: begin
                if (!anim_en) begin
                    w_state_nxt = ANIM_IDLE;
                    w_cnt_nxt   = '0;
                    w_frame_nxt = '0;
                end else if (frame_start) begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_nxt = '0;
                        // A single-frame image never leaves frame 0.
                        if (NUM_FRAMES > 1) begin
                            w_frame_nxt = (r_frame == c_frame_last) ? '0
                                        : r_frame + FRAME_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ANIM_IDLE;
                w_cnt_nxt   = '0;
                w_frame_nxt = '0;
            end
        endcase
    end

    assign frame_idx = r_frame;

endmodule : layer_compositor_anim_sequencer
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor
//  Description : Two-stage pixel compositor. Stage 1 registers the image ROM
//                address and copies of the pixel controls; stage 2 mixes the
//                ROM data or the highest-priority opaque layer and registers
//                the final 12-bit RGB on the pipelined pixel_tick.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                pixel_x, pixel_y     - coordinates of the next pixel
//                video_on             - visible region
//                pixel_tick           - pixel update strobe
//                frame_start          - VGA frame start pulse
//                mode                 - display mode
//                layer_region/rgb     - per-layer hit flags and colours
//                key_en               - per-layer colour-key enable
//                img_addr / img_data  - synchronous image ROM interface
//                rgb_out              - registered pixel colour
//                hit_valid/hit_layer  - winning layer information
//                frame_idx            - current animation frame
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int          NUM_LAYERS  = 8,
    parameter logic [11:0] KEY_COLOR   = c_key_color_def,
    parameter logic [11:0] BG_COLOR    = c_bg_color_def,
    parameter int          IMG_W       = 160,
    parameter int          IMG_H       = 120,
    parameter int          SCALE_SH    = 2,
    parameter int          NUM_FRAMES  = 2,
    parameter int          FRAME_TICKS = 24,
    parameter int          ADDR_W      = 16,
    localparam int         HIT_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int         FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [c_coord_w-1:0]          pixel_x,
    input  logic [c_coord_w-1:0]          pixel_y,
    input  logic                          video_on,
    input  logic                          pixel_tick,
    input  logic                          frame_start,
    input  logic [1:0]                    mode,
    input  logic [NUM_LAYERS-1:0]         layer_region,
    input  logic [NUM_LAYERS*c_rgb_w-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         key_en,
    output logic [ADDR_W-1:0]             img_addr,
    input  logic [c_rgb_w-1:0]            img_data,
    output logic [c_rgb_w-1:0]            rgb_out,
    output logic                          hit_valid,
    output logic [HIT_W-1:0]              hit_layer,
    output logic [FRAME_W-1:0]            frame_idx
);

    localparam logic [ADDR_W-1:0] c_frame_size = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] c_img_w      = ADDR_W'(IMG_W);

    // ------------------------------------------------------------------------
    // Animation sequencer
    // ------------------------------------------------------------------------
    logic w_anim_en;
    assign w_anim_en = (mode == MODE_ANIM);

    layer_compositor_anim_sequencer #(
        .NUM_FRAMES  (NUM_FRAMES),
        .FRAME_TICKS (FRAME_TICKS),
        .FRAME_W     (FRAME_W)
    ) u_anim_sequencer (
        .clk         (clk),
        .reset       (reset),
        .anim_en     (w_anim_en),
        .frame_start (frame_start),
        .frame_idx   (frame_idx)
    );

    // ------------------------------------------------------------------------
    // Stage 1: image address and control copies
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;

    // All arithmetic is ADDR_W wide so an oversized frame wraps silently.
    always_comb begin
        w_base = '0;
        if (mode == MODE_ANIM) begin
            w_base = ADDR_W'(frame_idx) * c_frame_size;
        end
        w_row  = ADDR_W'(pixel_y >> SCALE_SH) * c_img_w;
        w_col  = ADDR_W'(pixel_x >> SCALE_SH);
        w_addr = w_base + w_row + w_col;
    end

    logic                          r_video_on;
    mode_e                         r_mode;
    logic [NUM_LAYERS-1:0]         r_region;
    logic [NUM_LAYERS*c_rgb_w-1:0] r_layer_rgb;
    logic [NUM_LAYERS-1:0]         r_key_en;
    logic                          r_tick;
    logic [ADDR_W-1:0]             r_img_addr;

    // key_en travels with the layer data so a change lines up with the pixel
    // it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_img_addr  <= '0;
            r_video_on  <= 1'b0;
            r_mode      <= MODE_LAYERS;
            r_region    <= '0;
            r_layer_rgb <= '0;
            r_key_en    <= '0;
            r_tick      <= 1'b0;
        end else begin
            r_img_addr  <= w_addr;
            r_video_on  <= video_on;
            r_mode      <= mode_e'(mode);
            r_region    <= layer_region;
            r_layer_rgb <= layer_rgb;
            r_key_en    <= key_en;
            r_tick      <= pixel_tick;
        end
    end

    assign img_addr = r_img_addr;

    // ------------------------------------------------------------------------
    // Stage 2: layer priority and final mix
    // ------------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] w_opaque;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
        assign w_opaque[gi] = r_region[gi]
                            & ~(r_key_en[gi]
                                & (r_layer_rgb[gi*c_rgb_w +: c_rgb_w] == KEY_COLOR));
    end

    logic               w_win_valid;
    logic [HIT_W-1:0]   w_win_idx;
    logic [c_rgb_w-1:0] w_win_rgb;

    // Scan from the lowest priority upward so the last assignment made is the
    // lowest-index opaque layer.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_win_rgb   = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_win_valid = 1'b1;
                w_win_idx   = HIT_W'(i);
                w_win_rgb   = r_layer_rgb[i*c_rgb_w +: c_rgb_w];
            end
        end
    end

    logic [c_rgb_w-1:0] w_mix_rgb;
    logic               w_mix_hit;
    logic [HIT_W-1:0]   w_mix_layer;

    always_comb begin
        w_mix_rgb   = '0;
        w_mix_hit   = 1'b0;
        w_mix_layer = '0;
        if (r_video_on) begin
            case (r_mode)
                MODE_IMG, MODE_ANIM: begin
                    w_mix_rgb = img_data;
                end
                MODE_IMG_KEY: begin
                    w_mix_rgb = (img_data == KEY_COLOR) ? '0 : img_data;
                end
                MODE_LAYERS: begin
                    w_mix_rgb   = w_win_rgb;
                    w_mix_hit   = w_win_valid;
                    w_mix_layer = w_win_idx;
                end
                default: begin
                    w_mix_rgb = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out   <= '0;
            hit_valid <= 1'b0;
            hit_layer <= '0;
        end else if (r_tick) begin
            rgb_out   <= w_mix_rgb;
            hit_valid <= w_mix_hit;
            hit_layer <= w_mix_layer;
        end
    end

endmodule : layer_compositor
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_compositor
//  Description : Self-checking bench for layer_compositor. A behavioural model
//                predicts every output each cycle; directed vectors add
//                hand-computed literal expectations.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    localparam int FT = 24;
    localparam int NF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        pixel_tick;
    logic        frame_start;
    logic [1:0]  mode;
    logic [7:0]  layer_region;
    logic [95:0] layer_rgb;
    logic [7:0]  key_en;
    logic [15:0] img_addr;
    logic [11:0] img_data;
    logic [11:0] rgb_out;
    logic        hit_valid;
    logic [2:0]  hit_layer;
    logic [0:0]  frame_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .pixel_tick   (pixel_tick),
        .frame_start  (frame_start),
        .mode         (mode),
        .layer_region (layer_region),
        .layer_rgb    (layer_rgb),
        .key_en       (key_en),
        .img_addr     (img_addr),
        .img_data     (img_data),
        .rgb_out      (rgb_out),
        .hit_valid    (hit_valid),
        .hit_layer    (hit_layer),
        .frame_idx    (frame_idx)
    );

    // Image ROM contents: one keyed word at 324, a scrambled address elsewhere.
    function automatic logic [11:0] rom_word(input logic [15:0] a);
        if (a == 16'd324) return 12'h0f0;
        return a[11:0] ^ 12'h5a5;
    endfunction

    assign img_data = rom_word(img_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    function automatic logic [15:0] addr_of(input logic [9:0] x, input logic [9:0] y,
                                            input logic [1:0] md, input int fi);
        int a;
        a = ((md == 2'd2) ? fi * 160 * 120 : 0) + (int'(y) / 4) * 160 + int'(x) / 4;
        return 16'(a);
    endfunction

    function automatic void mix(input logic von, input logic [1:0] md, input logic [7:0] hits,
                                input logic [95:0] cols, input logic [7:0] ke,
                                input logic [11:0] rom, output logic [11:0] rgb,
                                output logic hv, output int hl);
        rgb = 12'h000;
        hv  = 1'b0;
        hl  = 0;
        if (!von) return;
        if (md == 2'd1 || md == 2'd2) begin
            rgb = rom;
        end else if (md == 2'd3) begin
            rgb = (rom == 12'h0f0) ? 12'h000 : rom;
        end else begin
            rgb = 12'hAAA;
            for (int i = 0; i < 8; i++) begin
                logic [11:0] c;
                c = cols[i*12 +: 12];
                if (hits[i] && !(ke[i] && c == 12'h0f0)) begin
                    rgb = c;
                    hv  = 1'b1;
                    hl  = i;
                    return;
                end
            end
        end
    endfunction

    logic        m_ok = 1'b0;
    int          m_fi, m_cnt, m_hl;
    logic        m_run, m_hv;
    logic [15:0] m_addr;
    logic [11:0] m_rgb;
    logic        p_tick, p_von;
    logic [1:0]  p_mode;
    logic [7:0]  p_hits, p_ke;
    logic [95:0] p_cols;

    task automatic model_step();
        if (reset) begin
            m_ok = 1'b1; m_fi = 0; m_cnt = 0; m_run = 1'b0;
            m_addr = '0; m_rgb = '0; m_hv = 1'b0; m_hl = 0;
            p_tick = 1'b0; p_von = 1'b0; p_mode = '0; p_hits = '0; p_ke = '0; p_cols = '0;
        end else begin
            if (p_tick) mix(p_von, p_mode, p_hits, p_cols, p_ke, rom_word(m_addr), m_rgb, m_hv, m_hl);
            m_addr = addr_of(pixel_x, pixel_y, mode, m_fi);
            p_tick = pixel_tick; p_von = video_on; p_mode = mode;
            p_hits = layer_region; p_ke = key_en; p_cols = layer_rgb;
            if (mode != 2'd2) begin
                m_run = 1'b0; m_cnt = 0; m_fi = 0;
            end else begin
                if (m_run && frame_start) begin
                    m_cnt++;
                    if (m_cnt == FT) begin
                        m_cnt = 0;
                        m_fi  = (m_fi + 1) % NF;
                    end
                end
                m_run = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            check("mdl_img_addr",  32'(img_addr),  32'(m_addr));
            check("mdl_rgb_out",   32'(rgb_out),   32'(m_rgb));
            check("mdl_hit_valid", 32'(hit_valid), 32'(m_hv));
            check("mdl_hit_layer", 32'(hit_layer), 32'(m_hl));
            check("mdl_frame_idx", 32'(frame_idx), 32'(m_fi));
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic von,
                         input logic [1:0] md, input logic [7:0] hits,
                         input logic [95:0] cols, input logic [7:0] ke);
        pixel_x = x; pixel_y = y; video_on = von; mode = md;
        layer_region = hits; layer_rgb = cols; key_en = ke;
        pixel_tick = 1'b1;
        @(negedge clk);
        pixel_tick = 1'b0;
        @(negedge clk);
    endtask

    logic [95:0] cols;

    initial begin
        reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; pixel_tick = 1'b0;
        frame_start = 1'b0; mode = 2'd0; layer_region = '0; layer_rgb = '0; key_en = '0;
        repeat (3) @(negedge clk);
        check("rst_rgb_out",   32'(rgb_out),   32'h000);
        check("rst_img_addr",  32'(img_addr),  32'h0);
        check("rst_frame_idx", 32'(frame_idx), 32'h0);
        check("rst_hit_valid", 32'(hit_valid), 32'h0);
        check("rst_hit_layer", 32'(hit_layer), 32'h0);
        reset = 1'b0;

        // Mode 0: priority and colour keying
        for (int i = 0; i < 8; i++) cols[i*12 +: 12] = 12'h800 + 12'(i);
        cols[2*12 +: 12] = 12'h123;
        cols[5*12 +: 12] = 12'h456;
        drive(10'd20, 10'd30, 1'b1, 2'd0, 8'b0010_0100, cols, 8'h00);
        check("m0_two_hits_rgb", 32'(rgb_out),   32'h123);
        check("m0_two_hits_hv",  32'(hit_valid), 32'h1);
        check("m0_two_hits_hl",  32'(hit_layer), 32'h2);
        cols[2*12 +: 12] = 12'h0f0;
        drive(10'd20, 10'd30, 1'b1, 2'd0, 8'b0010_0100, cols, 8'h04);
        check("m0_keyed_rgb", 32'(rgb_out),   32'h456);
        check("m0_keyed_hl",  32'(hit_layer), 32'h5);
        drive(10'd20, 10'd30, 1'b1, 2'd0, 8'b0010_0100, cols, 8'h00);
        check("m0_key_off_rgb", 32'(rgb_out),   32'h0f0);
        check("m0_key_off_hl",  32'(hit_layer), 32'h2);
        drive(10'd20, 10'd30, 1'b1, 2'd0, 8'h00, cols, 8'h00);
        check("m0_none_rgb", 32'(rgb_out),   32'hAAA);
        check("m0_none_hv",  32'(hit_valid), 32'h0);
        check("m0_none_hl",  32'(hit_layer), 32'h0);

        // Image modes at pixel (17,9)
        pixel_x = 10'd17; pixel_y = 10'd9; video_on = 1'b1; mode = 2'd1;
        layer_region = 8'h00; pixel_tick = 1'b1;
        @(negedge clk);
        check("m1_addr", 32'(img_addr), 32'd324);
        pixel_tick = 1'b0;
        @(negedge clk);
        check("m1_rgb", 32'(rgb_out), 32'h0f0);
        drive(10'd17, 10'd9, 1'b1, 2'd3, 8'h00, cols, 8'h00);
        check("m3_keyed_black", 32'(rgb_out), 32'h000);
        drive(10'd17, 10'd9, 1'b1, 2'd2, 8'h00, cols, 8'h00);
        check("m2_no_keying", 32'(rgb_out), 32'h0f0);

        // Animation: 48 frame_start pulses while in RUN
        for (int p = 1; p <= 48; p++) begin
            frame_start = 1'b1;
            if (p == 30) begin
                pixel_x = 10'd0; pixel_y = 10'd0; pixel_tick = 1'b1;
            end
            @(negedge clk);
            frame_start = 1'b0;
            pixel_tick  = 1'b0;
            if (p == 30) check("anim_addr_p30", 32'(img_addr), 32'd19200);
            if (p == 23 || p == 24 || p == 47 || p == 48)
                check("anim_frame_idx", 32'(frame_idx), (p >= 24 && p < 48) ? 32'h1 : 32'h0);
            @(negedge clk);
            if (p == 30) check("anim_rgb_p30", 32'(rgb_out), 32'hea5);
        end

        // video_on low blanks every mode
        drive(10'd17, 10'd9, 1'b0, 2'd2, 8'h00, cols, 8'h00);
        check("blank_m2_rgb", 32'(rgb_out), 32'h000);
        drive(10'd17, 10'd9, 1'b0, 2'd0, 8'b0010_0100, cols, 8'h00);
        check("blank_m0_rgb", 32'(rgb_out),   32'h000);
        check("blank_m0_hv",  32'(hit_valid), 32'h0);

        // Pulse coinciding with entry is ignored; pulse with exit is ignored
        mode = 2'd2; frame_start = 1'b1;
        @(negedge clk);
        repeat (FT - 1) @(negedge clk);
        check("entry_pulse_ignored", 32'(frame_idx), 32'h0);
        @(negedge clk);
        check("entry_24th_counted", 32'(frame_idx), 32'h1);
        mode = 2'd1;
        @(negedge clk);
        check("exit_clears_frame", 32'(frame_idx), 32'h0);
        frame_start = 1'b0;

        // Reset in the middle of an animation
        mode = 2'd2; video_on = 1'b1; pixel_x = 10'd100; pixel_y = 10'd50;
        @(negedge clk);
        frame_start = 1'b1; pixel_tick = 1'b1;
        repeat (FT) @(negedge clk);
        frame_start = 1'b0;
        check("pre_rst_frame_idx", 32'(frame_idx), 32'h1);
        check("pre_rst_rgb_nonzero", 32'(rgb_out != 12'h000), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_frame_idx", 32'(frame_idx), 32'h0);
        check("midrst_rgb_out",   32'(rgb_out),   32'h000);
        check("midrst_img_addr",  32'(img_addr),  32'h0);
        @(negedge clk);
        check("post_rst_1clk_rgb", 32'(rgb_out), 32'h000);
        @(negedge clk);
        check("post_rst_2clk_rgb", 32'(rgb_out), 32'h23c);
        pixel_tick = 1'b0;

        // Mixed traffic, checked against the model only
        key_en = 8'ha5;
        for (int c = 0; c < 400; c++) begin
            pixel_x  = 10'($urandom_range(639));
            pixel_y  = 10'($urandom_range(479));
            video_on = ($urandom_range(7) != 0);
            pixel_tick  = 1'($urandom_range(1));
            frame_start = ($urandom_range(2) == 0);
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            layer_region = 8'($urandom_range(255));
            for (int i = 0; i < 8; i++)
                layer_rgb[i*12 +: 12] = ($urandom_range(2) == 0) ? 12'h0f0 : 12'($urandom_range(4095));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_layer_compositor
`default_nettype wire
